// File: rtl/fwrisc_tcm_arbiter.sv
// Single-port TCM arbiter: loader > data > fetch, with a starvation bound that guarantees fetch progress.
// Optional grant statistics ports are built when FWRISC_ARB_STATS_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | sample core requests, pick a winner (or enter LOAD)
// LOAD    | loader owns the port; only loader writes are serviced
// ISSUE   | owner address/data/strobes registered onto the TCM port
// CAPTURE | TCM enable dropped; memory is reading the issued word
// RESP    | read word registered into owner's data output, ready pulsed
//
// Each state's actions are registered on its exit edge, so ready is seen
// while the arbiter is already back in IDLE/LOAD.

module fwrisc_tcm_arbiter #(
  parameter int TCM_AW       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              load_busy_i,
  input  logic              ld_valid_i,
  input  logic [TCM_AW-1:0] ld_addr_i,
  input  logic [31:0]       ld_wdata_i,
  output logic              ld_ready_o,
  input  logic              ivalid_i,
  input  logic [31:0]       iaddr_i,
  output logic [31:0]       idata_o,
  output logic              iready_o,
  input  logic              dvalid_i,
  input  logic [31:0]       daddr_i,
  input  logic [31:0]       dwdata_i,
  input  logic [3:0]        dstrb_i,
  input  logic              dwrite_i,
  output logic [31:0]       drdata_o,
  output logic              dready_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [TCM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
`ifdef FWRISC_ARB_STATS_EN
  ,
  output logic [15:0]       stat_igrant_o,
  output logic [15:0]       stat_dgrant_o,
  output logic [15:0]       stat_starve_o
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_CAPTURE, S_RESP} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_LD, OWN_I, OWN_D} owner_e;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [3:0]        streak_q, streak_d;
  logic              mem_en_q, mem_en_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [TCM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       idata_q, idata_d;
  logic [31:0]       drdata_q, drdata_d;
  logic              ld_ready_q, ld_ready_d;
  logic              iready_q, iready_d;
  logic              dready_q, dready_d;

  // Only the word-address bits of the byte addresses are used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iaddr_i[31:TCM_AW+2], iaddr_i[1:0],
                              daddr_i[31:TCM_AW+2], daddr_i[1:0]};

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    idata_d     = idata_q;
    drdata_d    = drdata_q;
    ld_ready_d  = 1'b0;
    iready_d    = 1'b0;
    dready_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!ivalid_i) streak_d = 4'd0;
        if (load_busy_i) begin
          state_d = S_LOAD;
        end else if (ivalid_i && (streak_q == STREAK_MAX)) begin
          owner_d  = OWN_I;
          streak_d = 4'd0;
          state_d  = S_ISSUE;
        end else if (dvalid_i) begin
          owner_d = OWN_D;
          if (ivalid_i && (streak_q < STREAK_MAX)) streak_d = streak_q + 4'd1;
          state_d = S_ISSUE;
        end else if (ivalid_i) begin
          owner_d  = OWN_I;
          streak_d = 4'd0;
          state_d  = S_ISSUE;
        end
      end

      S_LOAD: begin
        if (ld_valid_i) begin
          owner_d = OWN_LD;
          state_d = S_ISSUE;
        end else if (!load_busy_i) begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        mem_en_d = 1'b1;
        case (owner_q)
          OWN_LD: begin
            mem_addr_d  = ld_addr_i;
            mem_we_d    = 4'hF;
            mem_wdata_d = ld_wdata_i;
          end
          OWN_D: begin
            mem_addr_d  = daddr_i[TCM_AW+1:2];
            mem_we_d    = dwrite_i ? dstrb_i : 4'h0;
            mem_wdata_d = dwdata_i;
          end
          default: begin
            mem_addr_d  = iaddr_i[TCM_AW+1:2];
            mem_we_d    = 4'h0;
            mem_wdata_d = 32'h0;
          end
        endcase
        state_d = S_CAPTURE;
      end

      S_CAPTURE: begin
        mem_en_d = 1'b0;
        mem_we_d = 4'h0;
        state_d  = S_RESP;
      end

      S_RESP: begin
        case (owner_q)
          OWN_LD: ld_ready_d = 1'b1;
          OWN_D: begin
            drdata_d = mem_rdata_i;
            dready_d = 1'b1;
          end
          OWN_I: begin
            idata_d  = mem_rdata_i;
            iready_d = 1'b1;
          end
          default: ;
        endcase
        state_d = load_busy_i ? S_LOAD : S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      streak_q    <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      idata_q     <= 32'h0;
      drdata_q    <= 32'h0;
      ld_ready_q  <= 1'b0;
      iready_q    <= 1'b0;
      dready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      idata_q     <= idata_d;
      drdata_q    <= drdata_d;
      ld_ready_q  <= ld_ready_d;
      iready_q    <= iready_d;
      dready_q    <= dready_d;
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign idata_o     = idata_q;
  assign drdata_o    = drdata_q;
  assign ld_ready_o  = ld_ready_q;
  assign iready_o    = iready_q;
  assign dready_o    = dready_q;

`ifdef FWRISC_ARB_STATS_EN
  logic [15:0] stat_igrant_q, stat_dgrant_q, stat_starve_q;
  logic        core_grant;

  assign core_grant = (state_q == S_IDLE) && (state_d == S_ISSUE);

  // A starvation grant is one where data was also requesting and lost.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stat_igrant_q <= 16'h0;
      stat_dgrant_q <= 16'h0;
      stat_starve_q <= 16'h0;
    end else if (core_grant) begin
      if (owner_d == OWN_I) stat_igrant_q <= stat_igrant_q + 16'd1;
      if (owner_d == OWN_D) stat_dgrant_q <= stat_dgrant_q + 16'd1;
      if ((owner_d == OWN_I) && dvalid_i && (streak_q == STREAK_MAX))
        stat_starve_q <= stat_starve_q + 16'd1;
    end
  end

  assign stat_igrant_o = stat_igrant_q;
  assign stat_dgrant_o = stat_dgrant_q;
  assign stat_starve_o = stat_starve_q;
`endif

endmodule

// File: tb/tb_fwrisc_tcm_arbiter.sv
// Directed bench for fwrisc_tcm_arbiter with a synchronous-read TCM model.
// Covers loader priority, fetch/data paths, starvation ordering and async reset.

module tb_fwrisc_tcm_arbiter;
  localparam int TCM_AW = 12;

  logic              clock = 1'b0;
  logic              rst_n;
  logic              load_busy_i, ld_valid_i;
  logic [TCM_AW-1:0] ld_addr_i;
  logic [31:0]       ld_wdata_i;
  logic              ld_ready_o;
  logic              ivalid_i;
  logic [31:0]       iaddr_i, idata_o;
  logic              iready_o;
  logic              dvalid_i, dwrite_i;
  logic [31:0]       daddr_i, dwdata_i, drdata_o;
  logic [3:0]        dstrb_i;
  logic              dready_o;
  logic              mem_en_o;
  logic [3:0]        mem_we_o;
  logic [TCM_AW-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o, mem_rdata;
`ifdef FWRISC_ARB_STATS_EN
  logic [15:0]       stat_igrant_o, stat_dgrant_o, stat_starve_o;
`endif

  logic [31:0]       ram [0:(1<<TCM_AW)-1];
  logic              pre_en;
  logic [TCM_AW-1:0] pre_addr;
  logic [31:0]       pre_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  fwrisc_tcm_arbiter #(.TCM_AW(TCM_AW), .STARVE_LIMIT(4)) dut (
    .clock(clock), .rst_n(rst_n),
    .load_busy_i(load_busy_i), .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i),
    .ld_wdata_i(ld_wdata_i), .ld_ready_o(ld_ready_o),
    .ivalid_i(ivalid_i), .iaddr_i(iaddr_i), .idata_o(idata_o), .iready_o(iready_o),
    .dvalid_i(dvalid_i), .daddr_i(daddr_i), .dwdata_i(dwdata_i), .dstrb_i(dstrb_i),
    .dwrite_i(dwrite_i), .drdata_o(drdata_o), .dready_o(dready_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
`ifdef FWRISC_ARB_STATS_EN
    , .stat_igrant_o(stat_igrant_o), .stat_dgrant_o(stat_dgrant_o),
    .stat_starve_o(stat_starve_o)
`endif
  );

  // Synchronous-read RAM, read-before-write, byte-enabled writes.
  always @(posedge clock) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    if (mem_en_o) begin
      mem_rdata <= ram[mem_addr_o];
      for (int b = 0; b < 4; b++)
        if (mem_we_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [TCM_AW-1:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  function automatic logic rdy(input int which);
    case (which)
      0:       return ld_ready_o;
      1:       return iready_o;
      default: return dready_o;
    endcase
  endfunction

  task automatic wait_ready(input int which, input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!rdy(which) && cycles < budget);
  endtask

  initial begin
    int cyc;
    int cnt;
    int grants;
    logic [9:0] order;
    logic [31:0] dval, ival;

    rst_n = 1'b0; load_busy_i = 0; ld_valid_i = 0; ld_addr_i = '0; ld_wdata_i = 0;
    ivalid_i = 0; iaddr_i = 0; dvalid_i = 0; daddr_i = 0; dwdata_i = 0; dstrb_i = 0;
    dwrite_i = 0; pre_en = 0; pre_addr = '0; pre_data = 0;

    tick(); tick();
    chk("rst_mem_en", 32'(mem_en_o), 0);
    chk("rst_mem_we", 32'(mem_we_o), 0);
    chk("rst_readies", 32'({ld_ready_o, iready_o, dready_o}), 0);
    chk("rst_idata", idata_o, 0);
    rst_n = 1'b1;

    preload(12'd2, 32'h11223344);
    preload(12'd3, 32'hDEADBEEF);
    preload(12'd10, 32'hD0D0000A);
    preload(12'd11, 32'h1111000B);

    // Loader write with a fetch pending that must wait for LOAD to end.
    load_busy_i = 1; ivalid_i = 1; iaddr_i = 32'h80000014;
    tick();
    ld_valid_i = 1; ld_addr_i = 12'd5; ld_wdata_i = 32'h00000013;
    tick(); tick();
    chk("ld_mem_en", 32'(mem_en_o), 1);
    chk("ld_mem_we", 32'(mem_we_o), 32'hF);
    chk("ld_mem_addr", 32'(mem_addr_o), 5);
    chk("ld_mem_wdata", mem_wdata_o, 32'h00000013);
    tick();
    chk("ld_not_ready_yet", 32'(ld_ready_o), 0);
    tick();
    chk("ld_ready_pulse", 32'(ld_ready_o), 1);
    ld_valid_i = 0;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      cnt += int'(iready_o) + int'(ld_ready_o);
    end
    chk("load_blocks_core", cnt, 0);
    chk("ram5_written", ram[5], 32'h00000013);
    load_busy_i = 0;
    wait_ready(1, 20, cyc);
    chk("post_load_fetch_lat", cyc, 5);
    chk("post_load_fetch_data", idata_o, 32'h00000013);
    ivalid_i = 0;
    tick();

    // Fetch read of word 3.
    ivalid_i = 1; iaddr_i = 32'h8000000C;
    tick(); tick();
    chk("if_mem_addr", 32'(mem_addr_o), 3);
    chk("if_mem_we", 32'(mem_we_o), 0);
    tick();
    chk("if_not_ready_yet", 32'(iready_o), 0);
    tick();
    chk("if_ready", 32'(iready_o), 1);
    chk("if_data", idata_o, 32'hDEADBEEF);
    ivalid_i = 0;
    tick();
    chk("if_ready_single", 32'(iready_o), 0);

    // Byte write to word 2 lane 2, then read it back.
    dvalid_i = 1; dwrite_i = 1; daddr_i = 32'h80010008; dstrb_i = 4'b0100;
    dwdata_i = 32'h00AA0000;
    tick(); tick();
    chk("bw_mem_we", 32'(mem_we_o), 32'h4);
    chk("bw_mem_addr", 32'(mem_addr_o), 2);
    chk("bw_mem_wdata", mem_wdata_o, 32'h00AA0000);
    wait_ready(2, 10, cyc);
    chk("bw_lat", cyc, 2);
    dvalid_i = 0; dwrite_i = 0;
    tick();
    chk("bw_dready_single", 32'(dready_o), 0);
    chk("bw_ram2", ram[2], 32'h11AA3344);
    dvalid_i = 1; daddr_i = 32'h80000008;
    wait_ready(2, 10, cyc);
    chk("dr_lat", cyc, 4);
    chk("dr_data", drdata_o, 32'h11AA3344);
    dvalid_i = 0;
    tick();

    // Contention: both held, expect D,D,D,D,I repeating.
    dvalid_i = 1; daddr_i = 32'h00000028; ivalid_i = 1; iaddr_i = 32'h0000002C;
    grants = 0; cyc = 0; order = '0; dval = 0; ival = 0;
    while (grants < 10 && cyc < 60) begin
      tick();
      cyc++;
      if (iready_o) begin order[grants] = 1'b1; ival = idata_o; grants++; end
      else if (dready_o) begin dval = drdata_o; grants++; end
    end
    chk("grant_order", 32'(order), 32'h210);
    chk("contention_cycles", cyc, 40);
    chk("contention_ddata", dval, 32'hD0D0000A);
    chk("contention_idata", ival, 32'h1111000B);
    dvalid_i = 0; ivalid_i = 0;
    tick();
`ifdef FWRISC_ARB_STATS_EN
    chk("stat_igrant", 32'(stat_igrant_o), 4);
    chk("stat_dgrant", 32'(stat_dgrant_o), 10);
    chk("stat_starve", 32'(stat_starve_o), 2);
`endif

    // Asynchronous reset while the TCM enable is high.
    ivalid_i = 1; iaddr_i = 32'h00000008;
    tick(); tick();
    chk("pre_rst_mem_en", 32'(mem_en_o), 1);
    rst_n = 0;
    #1;
    chk("async_rst_mem_en", 32'(mem_en_o), 0);
    chk("async_rst_mem_addr", 32'(mem_addr_o), 0);
    chk("async_rst_idata", idata_o, 0);
    ivalid_i = 0;
    tick();
    rst_n = 1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      cnt += int'(iready_o) + int'(dready_o) + int'(ld_ready_o);
    end
    chk("no_ready_after_rst", cnt, 0);
    ivalid_i = 1; iaddr_i = 32'h8000000C;
    wait_ready(1, 20, cyc);
    chk("post_rst_fetch_lat", cyc, 4);
    chk("post_rst_fetch_data", idata_o, 32'hDEADBEEF);
    ivalid_i = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
